// File: rtl/rf_arb_pkg.sv
// Shared constants for the register-file write-port arbiter.
package rf_arb_pkg;
    localparam int NREGS = 16;
    localparam int REG_IDW = 4;
    localparam logic [REG_IDW-1:0] ZERO_REG = 4'd0;
    localparam int DEFAULT_DW = 16;
    localparam int GIDX_W = 3;
endpackage

// File: rtl/rf_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx,
    output logic            any_grant
);

    logic [PW-1:0] cand;

    // Walk the search order backwards so the candidate closest to ptr overrides the rest.
    always_comb begin
        grant = '0;
        idx = '0;
        any_grant = 1'b0;
        cand = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = PW'((int'(ptr) + k) % NREQ);
            if (valid[cand]) begin
                grant = '0;
                grant[cand] = 1'b1;
                idx = cand;
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port; registers the winning
// write for the decoder and drops writes to R0.
module rf_wr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW = DEFAULT_DW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [REG_IDW*NREQ-1:0] req_id,
    input  logic [DW*NREQ-1:0]      req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    wr_en,
    output logic [REG_IDW-1:0]      wr_id,
    output logic [DW-1:0]           wr_data,
    output logic [GIDX_W-1:0]       grant_idx,
    output logic                    dropped_r0
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]      ptr;
    logic [PW-1:0]      pick_idx;
    logic [NREQ-1:0]    pick_valid;
    logic [NREQ-1:0]    pick_grant;
    logic               pick_any;
    logic [REG_IDW-1:0] sel_id;
    logic [DW-1:0]      sel_data;

    assign pick_valid = (stall || rst) ? '0 : req_valid;
    assign req_ready  = pick_grant;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .valid     (pick_valid),
        .ptr       (ptr),
        .grant     (pick_grant),
        .idx       (pick_idx),
        .any_grant (pick_any)
    );

    always_comb begin
        sel_id = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_grant[i]) begin
                sel_id = req_id[i*REG_IDW +: REG_IDW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    // An R0 write is still consumed and advances the pointer, it just never reaches the decoder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            wr_en <= 1'b0;
            wr_id <= '0;
            wr_data <= '0;
            grant_idx <= '0;
            dropped_r0 <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            dropped_r0 <= 1'b0;
            if (pick_any) begin
                grant_idx <= GIDX_W'(pick_idx);
                if (pick_idx == PW'(NREQ - 1))
                    ptr <= '0;
                else
                    ptr <= pick_idx + 1'b1;
                if (sel_id == ZERO_REG) begin
                    dropped_r0 <= 1'b1;
                end else begin
                    wr_en <= 1'b1;
                    wr_id <= sel_id;
                    wr_data <= sel_data;
                end
            end
        end
    end

endmodule
